// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx : serial receiver for the board UART link (counterpart of uart_tx).
//
// Recovers start / 8 data bits LSB-first / optional even parity / stop frames
// from the asynchronous rx pin. It uses a free-running fractional-accumulator
// tick at OVERSAMPLE x the line rate. Each good byte is presented as a
// one-clock rx_valid strobe.
//
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit
// after the data bits. Without it, frames are 8N1 and parity_err is tied to 0.
//
// Ports
//   clk         in   1  system clock
//   reset       in   1  asynchronous reset, active-high
//   rx          in   1  serial line, asynchronous to clk, idle high
//   rx_data     out  8  last correctly received byte (held until the next one)
//   rx_valid    out  1  one-cycle strobe: rx_data updated this cycle
//   frame_err   out  1  one-cycle strobe: stop bit sampled low
//   parity_err  out  1  one-cycle strobe: parity mismatch
//   busy        out  1  high from start-bit acceptance until frame end
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_IN     = 40000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int SCNT_W = $clog2(OVERSAMPLE);

    localparam logic [27:0] STEP_W  = 28'(BAUD_RATE * OVERSAMPLE);
    localparam logic [27:0] LIMIT_W = 28'(CLK_IN);
    localparam logic [26:0] STEP    = 27'(BAUD_RATE * OVERSAMPLE);
    localparam logic [26:0] LIMIT   = 27'(CLK_IN);

    localparam logic [SCNT_W-1:0] HALF_M1 = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] FULL_M1 = SCNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    logic [SCNT_W-1:0] scnt;
    logic [2:0]        bidx;
    logic [7:0]        shift;
    logic [26:0]       acc;
    logic [27:0]       acc_sum;
    logic              tick;
    logic              bit_centre;
    logic              rx_p0;
    logic              rx_s;

`ifdef UART_RX_PARITY_EN
    logic              par_bit;
    logic              parity_err_r;

    // Even parity: data bits plus parity bit must XOR to zero.
    function automatic logic parity_bad(input logic [7:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

    // ---- stage p0/p1: two-flop synchroniser for the asynchronous line ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    // ---- oversample tick: fractional accumulator, free running ----
    // The wrapped value acc+STEP-CLK_IN is always below STEP, so 27-bit
    // modular arithmetic gives the exact remainder; only the compare needs
    // the carry bit.
    assign acc_sum = {1'b0, acc} + STEP_W;
    assign tick    = (acc_sum >= LIMIT_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (tick) begin
            acc <= acc + STEP - LIMIT;
        end else begin
            acc <= acc + STEP;
        end
    end

    assign bit_centre = tick && (scnt == FULL_M1);

    // ---- data capture: sampled at each data/parity bit centre ----
    always_ff @(posedge clk) begin
        if (state == DATA && bit_centre) begin
            shift <= {rx_s, shift[7:1]};
        end
`ifdef UART_RX_PARITY_EN
        if (state == PARITY && bit_centre) begin
            par_bit <= rx_s;
        end
`endif
    end

    // ---- frame FSM with registered strobes ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= WAIT_IDLE;
            scnt         <= '0;
            bidx         <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
            case (state)
                // Wait for the line to be seen high before arming, so a line
                // stuck low is not taken as an endless string of start bits.
                WAIT_IDLE: begin
                    if (tick && rx_s) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        scnt  <= '0;
                    end
                end

                // Confirm the start bit at its centre; a pulse shorter than
                // half a bit is a glitch and is dropped silently.
                START: begin
                    if (tick) begin
                        if (scnt == HALF_M1) begin
                            if (!rx_s) begin
                                state <= DATA;
                                scnt  <= '0;
                                bidx  <= '0;
                                busy  <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            scnt <= scnt + SCNT_W'(1);
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (scnt == FULL_M1) begin
                            scnt <= '0;
                            bidx <= bidx + 3'd1;
                            if (bidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            scnt <= scnt + SCNT_W'(1);
                        end
                    end
                end

                PARITY: begin
                    if (tick) begin
                        if (scnt == FULL_M1) begin
                            scnt  <= '0;
                            state <= STOP;
                        end else begin
                            scnt <= scnt + SCNT_W'(1);
                        end
                    end
                end

                // Decide at the stop-bit centre; returning to IDLE here (mid
                // stop bit) lets a back-to-back start edge be caught.
                STOP: begin
                    if (tick) begin
                        if (scnt == FULL_M1) begin
                            scnt <= '0;
                            busy <= 1'b0;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                                state     <= WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                            end else if (parity_bad(shift, par_bit)) begin
                                parity_err_r <= 1'b1;
                                state        <= IDLE;
`endif
                            end else begin
                                rx_valid <= 1'b1;
                                rx_data  <= shift;
                                state    <= IDLE;
                            end
                        end else begin
                            scnt <= scnt + SCNT_W'(1);
                        end
                    end
                end

                default: state <= WAIT_IDLE;
            endcase
        end
    end

endmodule
